// File: rtl/jimmy_io_arbiter.sv
// Two-requester round-robin front end for the jimmy adder core: grants one
// requester, applies its operands, skips stale result strobes, captures the sum.
module jimmy_io_arbiter #(
  parameter int SKIP_STROBES   = 1,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       jimmy_clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_a0,
  input  logic [7:0] req_b0,
  input  logic [7:0] req_a1,
  input  logic [7:0] req_b1,
  output logic [1:0] req_ready,
  output logic [1:0] rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic [7:0] in_port_0,
  output logic [7:0] in_port_1,
  input  logic [7:0] out_port_0,
  input  logic [3:0] out_strobe
);
  typedef enum logic [2:0] {IDLE, APPLY, DRAIN, CAPTURE, RESP} state_e;

  localparam logic [3:0]  SKIP_N = 4'(SKIP_STROBES);
  localparam logic [15:0] TMO_N  = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic [7:0]  op_a_q, op_a_d, op_b_q, op_b_d;
  logic [3:0]  drain_q, drain_d;
  logic [15:0] tmo_q, tmo_d;
  logic        strobe_q, strobe_d;
  logic [7:0]  hold_q, hold_d;
  logic [1:0]  req_ready_q, req_ready_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic [7:0]  in_port_0_q, in_port_0_d, in_port_1_q, in_port_1_d;

  logic        fall;
  logic        winner;
  logic [1:0]  grant_onehot;
  logic [15:0] tmo_inc;
  logic [3:0]  drain_inc;
  logic        unused_strobe;

  assign unused_strobe = ^out_strobe[3:1];
  assign fall          = strobe_q & ~out_strobe[0];
  // On a tie the requester not served last wins; a lone request wins outright.
  assign winner        = (&req_valid) ? ~last_grant_q : req_valid[1];
  assign grant_onehot  = grant_q ? 2'b10 : 2'b01;
  assign tmo_inc       = tmo_q + 16'd1;
  assign drain_inc     = drain_q + 4'd1;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    drain_d       = drain_q;
    tmo_d         = tmo_q;
    strobe_d      = out_strobe[0];
    // Keeps the result presented during the most recent strobe-high cycle.
    hold_d        = out_strobe[0] ? out_port_0 : hold_q;
    req_ready_d   = 2'b00;
    rsp_valid_d   = 2'b00;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = 1'b0;
    in_port_0_d   = in_port_0_q;
    in_port_1_d   = in_port_1_q;

    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d      = winner;
          last_grant_d = winner;
          req_ready_d  = winner ? 2'b10 : 2'b01;
          op_a_d       = winner ? req_a1 : req_a0;
          op_b_d       = winner ? req_b1 : req_b0;
          state_d      = APPLY;
        end
      end
      APPLY: begin
        in_port_0_d = op_a_q;
        in_port_1_d = op_b_q;
        drain_d     = 4'd0;
        tmo_d       = 16'd0;
        state_d     = (SKIP_N == 4'd0) ? CAPTURE : DRAIN;
      end
      DRAIN: begin
        tmo_d = tmo_inc;
        if (tmo_inc == TMO_N) begin
          rsp_valid_d   = grant_onehot;
          rsp_data_d    = 8'd0;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else if (fall) begin
          drain_d = drain_inc;
          if (drain_inc == SKIP_N) state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        tmo_d = tmo_inc;
        // A strobe edge landing on the expiry cycle still delivers real data.
        if (fall) begin
          rsp_valid_d = grant_onehot;
          rsp_data_d  = hold_q;
          state_d     = RESP;
        end else if (tmo_inc == TMO_N) begin
          rsp_valid_d   = grant_onehot;
          rsp_data_d    = 8'd0;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge jimmy_clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      grant_q       <= 1'b0;
      op_a_q        <= 8'd0;
      op_b_q        <= 8'd0;
      drain_q       <= 4'd0;
      tmo_q         <= 16'd0;
      strobe_q      <= 1'b0;
      hold_q        <= 8'd0;
      req_ready_q   <= 2'b00;
      rsp_valid_q   <= 2'b00;
      rsp_data_q    <= 8'd0;
      rsp_timeout_q <= 1'b0;
      in_port_0_q   <= 8'd0;
      in_port_1_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      drain_q       <= drain_d;
      tmo_q         <= tmo_d;
      strobe_q      <= strobe_d;
      hold_q        <= hold_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      in_port_0_q   <= in_port_0_d;
      in_port_1_q   <= in_port_1_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign in_port_0   = in_port_0_q;
  assign in_port_1   = in_port_1_q;
endmodule

// File: doc/jimmy_io_arbiter.md
JIMMY_IO_ARBITER -- requirements
Module: jimmy_io_arbiter

Interface
REQ-001 Parameter SKIP_STROBES, default 1: out_strobe[0] falling edges discarded after new operands are applied; legal range 0-15.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000: maximum cycles spent waiting for a result; legal range 1-65535.
REQ-003 Port jimmy_clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset, sampled on the jimmy_clk rising edge.
REQ-005 Port req_valid  input  2  per-requester request; held high until the matching req_ready pulse.
REQ-006 Port req_a0, req_b0, req_a1, req_b1  input  8 each  operands for requester 0 and requester 1.
REQ-007 Port req_ready  output  2  one-cycle grant pulse; operands are latched in the same cycle.
REQ-008 Port rsp_valid  output  2  one-cycle response pulse to the granted requester.
REQ-009 Port rsp_data  output  8  result; valid while rsp_valid is non-zero.
REQ-010 Port rsp_timeout  output  1  high with rsp_valid when the result timed out.
REQ-011 Port in_port_0, in_port_1  output  8 each  operands driven to the jimmy in_port_0 and in_port_1 inputs.
REQ-012 Port out_port_0  input  8  jimmy result port.
REQ-013 Port out_strobe  input  4  jimmy output strobes; only bit 0 is used, bits 3:1 are ignored.

Function
REQ-014 States SHALL be: IDLE, APPLY, DRAIN, CAPTURE, RESP; exactly one state is active at any time.
REQ-015 IDLE: if any req_valid is high, SHALL pulse req_ready for exactly one winner, latch the winner's operands, record the winner, and move to APPLY.
REQ-016 Arbitration SHALL be round-robin: when both requests are high, grant the requester not granted last; last_grant resets to 1, so requester 0 wins the first tie.
REQ-017 A single requesting line SHALL be granted immediately, regardless of last_grant.
REQ-018 APPLY (1 cycle): SHALL drive the latched operands on in_port_0/in_port_1, clear drain and timeout counters, then go to DRAIN.
REQ-019 A strobe falling edge SHALL be detected synchronously as a registered out_strobe[0]=1 with current out_strobe[0]=0.
REQ-020 DRAIN: each falling edge SHALL increment the drain count; when the count reaches SKIP_STROBES, go to CAPTURE. With SKIP_STROBES=0, go straight to CAPTURE.
REQ-021 CAPTURE: on a falling edge, SHALL store the out_port_0 value registered in the last cycle out_strobe[0] was high, then go to RESP.
REQ-022 The timeout counter SHALL increment every cycle in DRAIN and CAPTURE; on reaching TIMEOUT_CYCLES, go to RESP with rsp_timeout=1 and rsp_data=0.
REQ-023 If a falling edge and timeout expiry occur in the same CAPTURE cycle, the falling edge SHALL win (valid result, rsp_timeout=0).
REQ-024 RESP (1 cycle): SHALL assert rsp_valid only for the granted requester, with rsp_data and rsp_timeout, then return to IDLE; no grant is issued in RESP.
REQ-025 in_port_0/in_port_1 SHALL hold the last applied operands until the next APPLY.
REQ-026 Falling edges seen in IDLE or RESP SHALL be ignored.
REQ-027 req_valid dropping after a grant SHALL NOT affect the transaction in progress.
REQ-028 Minimum grant-to-response latency SHALL be 3 cycles (APPLY, CAPTURE edge, RESP) when SKIP_STROBES=0.

Reset
REQ-029 While reset=0 at a rising edge: state SHALL go to IDLE; last_grant=1; counters and strobe history cleared; req_ready, rsp_valid, rsp_timeout, rsp_data, in_port_0 and in_port_1 all 0.
REQ-030 Reset in any state, including mid-DRAIN or mid-CAPTURE, SHALL abort the transaction with no rsp_valid pulse; the first grant after release follows REQ-016.

Verification
REQ-031 Single request: req_valid=01, a0=2, b0=3, jimmy running the adder program -> req_ready=01 one cycle, in_port_0=2, in_port_1=3, the first strobe (stale sum) is discarded, rsp_valid=01 with rsp_data=5, rsp_timeout=0.
REQ-032 Tie after reset: req_valid=11, (21,100) on requester 0 and (7,8) on requester 1 -> requester 0 is served first with 121, then requester 1 with 15; the grants never overlap.
REQ-033 Fairness: both requests held continuously for 4 transactions -> grant order 0,1,0,1.
REQ-034 Timeout: TIMEOUT_CYCLES=20, out_strobe held at 0 -> rsp_valid 20 cycles after entering DRAIN, with rsp_timeout=1 and rsp_data=0.
REQ-035 Reset mid-CAPTURE: reset=0 for one cycle -> all outputs 0, no rsp_valid; a later request completes normally.
REQ-036 Same-cycle event: falling edge coincides with timeout expiry -> rsp_timeout=0 and the captured value is returned.
